// File: rtl/servo_bank.sv
// servo_bank: multi-channel servo PWM generator sharing one period timebase.
// Each channel maps a position code to a pulse width in microseconds. New
// targets are applied only at period boundaries, and the width can be
// slew-limited so that it ramps toward the target over several periods.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   pos_i          packed position codes, channel k at [k*POS_BITS +: POS_BITS]
//   load_i         per-channel strobe that captures that channel's pos_i slice
//   en_i           per-channel output enable
//   pwm_out        registered servo pulse outputs
//   settled_o      per channel, high when the current width equals the pending target
//   period_start_o one-cycle pulse in the first cycle of every period
module servo_bank #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CLK_FREQ_HZ = 12000000,
  parameter int unsigned PERIOD_US   = 20000,
  parameter int unsigned POS_BITS    = 2,
  parameter int unsigned MIN_US      = 500,
  parameter int unsigned US_PER_LSB  = 500,
  parameter int unsigned SLEW_US     = 0,
  parameter int unsigned HOME_POS    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*POS_BITS-1:0] pos_i,
  input  logic [NUM_CH-1:0]          load_i,
  input  logic [NUM_CH-1:0]          en_i,
  output logic [NUM_CH-1:0]          pwm_out,
  output logic [NUM_CH-1:0]          settled_o,
  output logic                       period_start_o
);

  localparam int unsigned CYC_PER_US = CLK_FREQ_HZ / 1000000;
  localparam int unsigned PS_W       = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
  localparam int unsigned US_W       = $clog2(PERIOD_US);
  localparam int unsigned AW         = US_W + 1;
  localparam int unsigned HOME_W     = MIN_US + HOME_POS * US_PER_LSB;
  localparam int unsigned MAX_W      = MIN_US + ((1 << POS_BITS) - 1) * US_PER_LSB;
  // A step larger than the period can never be needed; clamping keeps the cast exact.
  localparam int unsigned SLEW_C     = (SLEW_US > PERIOD_US) ? PERIOD_US : SLEW_US;

  // Reject parameter sets the timebase or width arithmetic cannot represent.
  if ((CYC_PER_US == 0) || (CLK_FREQ_HZ % 1000000 != 0)) begin : g_bad_clk
    $error("servo_bank: CLK_FREQ_HZ must be a non-zero multiple of 1 MHz");
  end
  if (MAX_W >= PERIOD_US) begin : g_bad_width
    $error("servo_bank: largest pulse width must be shorter than PERIOD_US");
  end

  logic [PS_W-1:0]     presc;
  logic [US_W-1:0]     us_cnt;
  logic                us_tick;
  logic                boundary;
  logic [POS_BITS-1:0] pend  [NUM_CH];
  logic [US_W-1:0]     cur_w [NUM_CH];
  logic [AW-1:0]       tgt_w [NUM_CH];
  logic [AW-1:0]       nxt_w [NUM_CH];

  assign us_tick  = (presc == PS_W'(CYC_PER_US - 1));
  assign boundary = us_tick && (us_cnt == US_W'(PERIOD_US - 1));

  // Per-channel target width, slew-limited next width, and settled flag.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      tgt_w[k]     = AW'(MIN_US) + AW'(pend[k]) * AW'(US_PER_LSB);
      nxt_w[k]     = AW'(cur_w[k]);
      settled_o[k] = (AW'(cur_w[k]) == tgt_w[k]);
      if (SLEW_C == 0) begin
        nxt_w[k] = tgt_w[k];
      end else if (AW'(cur_w[k]) < tgt_w[k]) begin
        if ((tgt_w[k] - AW'(cur_w[k])) > AW'(SLEW_C)) begin
          nxt_w[k] = AW'(cur_w[k]) + AW'(SLEW_C);
        end else begin
          nxt_w[k] = tgt_w[k];
        end
      end else if (AW'(cur_w[k]) > tgt_w[k]) begin
        if ((AW'(cur_w[k]) - tgt_w[k]) > AW'(SLEW_C)) begin
          nxt_w[k] = AW'(cur_w[k]) - AW'(SLEW_C);
        end else begin
          nxt_w[k] = tgt_w[k];
        end
      end
    end
  end

  // Timebase, per-channel width registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc          <= '0;
      us_cnt         <= '0;
      pwm_out        <= '0;
      period_start_o <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        pend[k]  <= POS_BITS'(HOME_POS);
        cur_w[k] <= US_W'(HOME_W);
      end
    end else begin
      presc <= us_tick ? '0 : presc + PS_W'(1);
      if (us_tick) begin
        us_cnt <= (us_cnt == US_W'(PERIOD_US - 1)) ? '0 : us_cnt + US_W'(1);
      end
      period_start_o <= boundary;
      for (int k = 0; k < NUM_CH; k++) begin
        pwm_out[k] <= en_i[k] && (us_cnt < cur_w[k]);
        // The boundary update sees pend from before this edge, so a load on
        // the boundary clock only takes effect one period later.
        if (boundary) begin
          cur_w[k] <= US_W'(nxt_w[k]);
        end
        if (load_i[k]) begin
          pend[k] <= pos_i[k*POS_BITS +: POS_BITS];
        end
      end
    end
  end

endmodule

// File: tb/tb_servo_bank.sv
// tb_servo_bank: drives two servo_bank instances (direct jump and slew 400 us)
// from shared inputs and compares every cycle against a time-based model,
// plus explicit per-period pulse widths derived by hand.
module tb_servo_bank;

  localparam int CYC  = 2;
  localparam int PER  = 4000;
  localparam int MINW = 500;
  localparam int LSB  = 500;
  localparam int PCLK = CYC * PER;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pos = '0;
  logic [1:0] load = '0;
  logic [1:0] en = '0;
  logic [1:0] pwm0, set0, pwm1, set1;
  logic       ps0, ps1;

  servo_bank #(
    .NUM_CH(2), .CLK_FREQ_HZ(2000000), .PERIOD_US(PER), .POS_BITS(2),
    .MIN_US(MINW), .US_PER_LSB(LSB), .SLEW_US(0), .HOME_POS(0)
  ) u_snap (
    .clk(clk), .rst(rst), .pos_i(pos), .load_i(load), .en_i(en),
    .pwm_out(pwm0), .settled_o(set0), .period_start_o(ps0)
  );

  servo_bank #(
    .NUM_CH(2), .CLK_FREQ_HZ(2000000), .PERIOD_US(PER), .POS_BITS(2),
    .MIN_US(MINW), .US_PER_LSB(LSB), .SLEW_US(400), .HOME_POS(0)
  ) u_slew (
    .clk(clk), .rst(rst), .pos_i(pos), .load_i(load), .en_i(en),
    .pwm_out(pwm1), .settled_o(set1), .period_start_o(ps1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model state: time since reset, widths in us, pending codes.
  int         t = 0;
  int         m_cur [2][2];
  int         m_pend [2];
  logic [1:0] e_pwm [2];
  logic       e_ps;
  bit         main_on = 0;
  int         meas [2][2][8];
  logic       set_s [5];
  int         ps_cnt = 0;

  function automatic int width_of(input int code);
    return MINW + code * LSB;
  endfunction

  function automatic int slew_of(input int d);
    return (d == 0) ? 0 : 400;
  endfunction

  // Width after one period: move toward the target by at most the slew limit.
  function automatic int approach(input int cur, input int tgt, input int s);
    int delta;
    delta = tgt - cur;
    if (s == 0) return tgt;
    if (delta > s) delta = s;
    if (delta < -s) delta = -s;
    return cur + delta;
  endfunction

  task automatic model_edge();
    int us;
    bit bnd;
    if (rst) begin
      t = 0;
      e_ps = 1'b0;
      for (int k = 0; k < 2; k++) m_pend[k] = 0;
      for (int d = 0; d < 2; d++) begin
        e_pwm[d] = '0;
        for (int k = 0; k < 2; k++) m_cur[d][k] = width_of(0);
      end
    end else begin
      us  = (t / CYC) % PER;
      bnd = ((t % PCLK) == PCLK - 1);
      e_ps = bnd;
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 2; k++) begin
          e_pwm[d][k] = en[k] && (us < m_cur[d][k]);
          if (bnd) m_cur[d][k] = approach(m_cur[d][k], width_of(m_pend[k]), slew_of(d));
        end
      if (load[0]) m_pend[0] = int'(pos[1:0]);
      if (load[1]) m_pend[1] = int'(pos[3:2]);
      t++;
    end
  endtask

  task automatic step();
    int   tb;
    bit   was_rst;
    logic [1:0] es [2];
    @(posedge clk);
    tb = t;
    was_rst = rst;
    model_edge();
    #1;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 2; k++) es[d][k] = (m_cur[d][k] == width_of(m_pend[k]));
    check("cycle", 32'({ps1, ps0, set1, set0, pwm1, pwm0}),
          32'({e_ps, e_ps, es[1], es[0], e_pwm[1], e_pwm[0]}));
    if (main_on && !was_rst) begin
      if (tb / PCLK < 8) begin
        meas[0][0][tb / PCLK] += int'(pwm0[0]);
        meas[0][1][tb / PCLK] += int'(pwm0[1]);
        meas[1][0][tb / PCLK] += int'(pwm1[0]);
        meas[1][1][tb / PCLK] += int'(pwm1[1]);
      end
      if ((tb % PCLK) == 4000 && (tb / PCLK) < 5) set_s[tb / PCLK] = set1[0];
      ps_cnt += int'(ps0);
    end
  endtask

  // Inputs for the edge whose model time is c.
  task automatic drive(input int c);
    pos  = 4'($urandom);
    load = 2'b00;
    en   = 2'b11;
    if (c == 200) begin
      load = 2'b01; pos[1:0] = 2'd3;
    end
    if (c == PCLK + 200) begin
      load = 2'b10; pos[3:2] = 2'd3;
    end
    if (c == 5 * PCLK - 1) begin
      load = 2'b01; pos[1:0] = 2'd2;
    end
    if (c >= 3 * PCLK + 20 && c < 5 * PCLK - 100) en[1] = 1'b0;
    if (c >= 6 * PCLK + 100) begin
      en[1] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 499) == 0) load[1] = 1'b1;
    end
  endtask

  initial begin
    int cnt;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 8; p++) meas[d][k][p] = 0;
    for (int p = 0; p < 5; p++) set_s[p] = 1'bx;

    repeat (3) step();
    check("rst_out", 32'({ps1, ps0, pwm1, pwm0}), 32'h0);
    check("rst_settled", 32'({set1, set0}), 32'hf);

    rst = 1'b0;
    main_on = 1;
    while (t < 7 * PCLK + 400) begin
      drive(t);
      step();
    end
    main_on = 0;

    // Reset in the middle of ch0's 1500 us pulse.
    check("pre_rst_hi", 32'(pwm0[0]), 32'h1);
    rst = 1'b1; load = 2'b00; en = 2'b11;
    step();
    check("rst_pwm", 32'({pwm1, pwm0}), 32'h0);
    rst = 1'b0;
    cnt = 0;
    repeat (3000) begin
      step();
      cnt += int'(pwm0[0]) + int'(pwm0[1]) + int'(pwm1[0]) + int'(pwm1[1]);
    end
    check("post_rst_hi", 32'(cnt), 32'd4000);
    check("post_rst_set", 32'({set1, set0}), 32'hf);

    // Hand-derived pulse widths in clocks per period.
    check("snap_c0_p0", 32'(meas[0][0][0]), 32'd1000);
    check("snap_c0_p1", 32'(meas[0][0][1]), 32'd4000);
    check("snap_c0_p5", 32'(meas[0][0][5]), 32'd4000);
    check("snap_c0_p6", 32'(meas[0][0][6]), 32'd3000);
    check("snap_c1_p0", 32'(meas[0][1][0]), 32'd1000);
    check("snap_c1_p1", 32'(meas[0][1][1]), 32'd1000);
    check("snap_c1_p2", 32'(meas[0][1][2]), 32'd4000);
    check("slew_c0_p0", 32'(meas[1][0][0]), 32'd1000);
    check("slew_c0_p1", 32'(meas[1][0][1]), 32'd1800);
    check("slew_c0_p2", 32'(meas[1][0][2]), 32'd2600);
    check("slew_c0_p3", 32'(meas[1][0][3]), 32'd3400);
    check("slew_c0_p4", 32'(meas[1][0][4]), 32'd4000);
    check("slew_c0_p5", 32'(meas[1][0][5]), 32'd4000);
    check("slew_c0_p6", 32'(meas[1][0][6]), 32'd3200);
    check("slew_c1_p1", 32'(meas[1][1][1]), 32'd1000);
    check("slew_c1_p2", 32'(meas[1][1][2]), 32'd1800);
    check("slew_c1_p3", 32'(meas[1][1][3]), 32'd20);
    check("slew_c1_p4", 32'(meas[1][1][4]), 32'd0);
    check("slew_c1_p5", 32'(meas[1][1][5]), 32'd4000);
    for (int p = 0; p < 5; p++)
      check("slew_settled", 32'(set_s[p]), (p == 4) ? 32'h1 : 32'h0);
    check("period_starts", 32'(ps_cnt), 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/servo_bank.md
# servo_bank

Multi-channel servo PWM generator, the parametrised successor to the two-servo driver in the motor top level. One shared period timebase drives `NUM_CH` independent channels. Each channel maps a `POS_BITS`-wide position code to a pulse width in microseconds, applies new targets only at period boundaries (glitch-free), and ramps toward each target at a bounded slew rate. It sits between the position-decode logic and the `pwm_out` pins.

## Interface
- `NUM_CH`, default 2: number of servo channels.
- `CLK_FREQ_HZ`, default 12000000: clock frequency. Must be an integer multiple of 1 MHz.
- `PERIOD_US`, default 20000: PWM period in µs.
- `POS_BITS`, default 2: position code width.
- `MIN_US`, default 500: pulse width for code 0.
- `US_PER_LSB`, default 500: µs added per code LSB.
- `SLEW_US`, default 0: maximum width change per period in µs. 0 means the width jumps directly to the target.
- `HOME_POS`, default 0: position code loaded at reset.
- Elaboration check: `MIN_US + (2^POS_BITS-1)*US_PER_LSB < PERIOD_US`.
- `clk`, in, 1: single system clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `pos_i`, in, `NUM_CH*POS_BITS`: packed position codes. Channel k occupies bits `[k*POS_BITS +: POS_BITS]`.
- `load_i`, in, `NUM_CH`: per-channel strobe that captures `pos_i` for that channel.
- `en_i`, in, `NUM_CH`: per-channel output enable.
- `pwm_out`, out, `NUM_CH`: servo pulse outputs.
- `settled_o`, out, `NUM_CH`: high when the current width equals the pending target width.
- `period_start_o`, out, 1: one-cycle pulse at each period boundary.

## Operation
- Prescaler: counts 0 to `CYC_PER_US-1`, where `CYC_PER_US = CLK_FREQ_HZ/1e6`. It asserts `us_tick` when at `CYC_PER_US-1`.
- µs counter `us_cnt`: width `$clog2(PERIOD_US)`. Advances on `us_tick` and wraps from `PERIOD_US-1` to 0.
- Boundary event: the `us_tick` on which `us_cnt` goes from `PERIOD_US-1` to 0.
- Per-channel registers:
  - `pend`: `POS_BITS` wide.
  - `cur_w`: µs width, same width as `us_cnt`.
- Target width: `tgt_w = MIN_US + pend*US_PER_LSB`.
- Load: if `load_i[k]` is high on a clock edge, `pend[k]` takes the channel's `pos_i` slice on that edge.
- Boundary update, for each channel:
  - If `SLEW_US == 0`: `cur_w <= tgt_w`.
  - Else if `cur_w < tgt_w`: `cur_w <= cur_w + min(SLEW_US, tgt_w - cur_w)`.
  - Else if `cur_w > tgt_w`: `cur_w <= cur_w - min(SLEW_US, cur_w - tgt_w)`.
  - Else `cur_w` holds.
  - `tgt_w` here is computed from the `pend` value before the edge.
- Load coinciding with a boundary: `pend` captures the new code, but the boundary update uses the old `pend`. The new target takes effect at the next boundary.
- `cur_w` changes only at boundaries, so pulses are never truncated or extended mid-period.
- Output: `pwm_out[k] <= en_i[k] && (us_cnt < cur_w[k])`, registered.
- Disabling a channel forces its output low but does not freeze `cur_w`; slewing continues.
- Re-enabling takes effect on the next clock. A partial pulse is permitted on the re-enable period.
- `settled_o[k] = (cur_w[k] == tgt_w[k])`, combinational from registers.
- Arithmetic: width math is done at width `$clog2(PERIOD_US)+1`. No overflow is possible given the elaboration check.

## Timing
- Reset values:
  - prescaler = 0, `us_cnt` = 0.
  - `pend` = `HOME_POS` for every channel.
  - `cur_w` = `MIN_US + HOME_POS*US_PER_LSB`.
  - `pwm_out` = 0, `period_start_o` = 0.
  - `settled_o` = all ones.
- First edge after reset deasserts: `pwm_out` goes high for each enabled channel with `cur_w > 0`.
- `pwm_out` lags `us_cnt` by 1 clk. The pulse width is `cur_w*CYC_PER_US` clocks, exact.
- `period_start_o`: registered, high for 1 clk in the cycle after the boundary event, i.e. while `us_cnt == 0` and the prescaler is 0.
- Load-to-output latency: the new width appears in the first full period after the next boundary.
- With slew active, reaching the target takes `ceil(|Δw|/SLEW_US)` periods.
- Reset asserted mid-period: on the next edge all state returns to reset values and `pwm_out` drops low immediately (synchronous).

## Test plan
- Bench overrides: `CLK_FREQ_HZ=2000000` (`CYC_PER_US=2`), `PERIOD_US=4000`, `MIN_US=500`, `US_PER_LSB=500`, `POS_BITS=2`, `NUM_CH=2`.
- Reset, then `en_i=2'b11`, no loads:
  - Both outputs show a 1000-clk high pulse every 8000 clks.
  - `period_start_o` is a 1-clk pulse every 8000 clks.
  - `settled_o=2'b11`.
- `SLEW_US=0`, load ch0 code 3 at `us_cnt=100`:
  - Current period keeps the 1000-clk pulse.
  - From the next period, ch0 pulse is 4000 clks (2000 µs). ch1 is unchanged.
- `SLEW_US=400`, load ch1 code 3 (500 µs to 2000 µs):
  - Widths per period: 900, 1300, 1700, 2000 µs, then hold.
  - `settled_o[1]` low until the 4th boundary, high afterwards.
- `load_i[0]` asserted on the boundary clock with code 2:
  - That boundary applies the old code; 1500 µs takes effect one period later.
- `en_i[0]=0` while ch0 slews:
  - `pwm_out[0]` stays 0.
  - On re-enable, the width equals the slewed value, not the value at disable time.
- Assert `rst` mid-pulse:
  - `pwm_out` is 0 on the next clk.
  - After release, `us_cnt` restarts from 0 and `cur_w=500`.
